load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the RV32I core's memory stage and the word-organised zero-delay RAM. Accepts one load or store per request handshake, drives word-aligned RAM accesses, sign/zero-extends byte and halfword loads, and performs byte/halfword stores as two-cycle read-modify-write sequences because the RAM only writes whole 32-bit words. Misaligned or illegal accesses are rejected with a fault pulse and no RAM side effect.

## Interface
- dataW, 32, data word width; only 32 supported
- RAMAddrSize, 32, byte-address width shared with the RAM
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req  in  1  core request; sampled only while ready=1
- isStore  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  RAMAddrSize  byte address
- storeData  in  dataW  store source; low byte/halfword used for SB/SH
- ready  out  1  unit idle, request accepted this cycle if req=1
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done; 1 = misaligned/illegal, access dropped
- loadData  out  dataW  extended load result; held until next load completes
- RAMAddr  out  RAMAddrSize  word-aligned address to RAM, {addr[31:2],2'b00}
- RAMDataOut  out  dataW  write data to RAM DataIn
- RAMWriteControl  out  1  RAM write enable for the current edge
- RAMOut  in  dataW  combinational RAM read data

## Operation
- States: IDLE, ACCESS, WRITE. ready = (state==IDLE).
- Accept (IDLE, req=1): register isStore, funct3, addr, storeData.
  - Legality: loads funct3 in {000,001,010,100,101}; stores in {000,001,010}; H/HU/SH need addr[0]=0; W/SW need addr[1:0]=00.
  - Illegal: stay IDLE; next cycle done=1, fault=1; no RAM write, loadData unchanged.
  - Legal: go to ACCESS.
- ACCESS: RAMAddr = registered word address.
  - Load: select lane (byte k = addr[1:0] at bits [8k+7:8k], halfword at addr[1]*16), sign-extend for B/H, zero-extend for BU/HU; capture into loadData; -> IDLE, done=1 next cycle.
  - SW: RAMWriteControl=1, RAMDataOut=storeData; -> IDLE, done=1 next cycle.
  - SB/SH: merged = RAMOut with addressed lane(s) replaced by storeData[7:0]/[15:0]; register merged; -> WRITE.
- WRITE: RAMAddr unchanged, RAMWriteControl=1, RAMDataOut=merged; -> IDLE, done=1 next cycle.
- IDLE outputs: RAMAddr=0, RAMDataOut=0, RAMWriteControl=0.
- Writes to RAM words 0/1 (input ports) are issued normally; the RAM blocks them; unit reports done, fault=0.
- RAMWriteControl is decoded from state only, never asserted in IDLE.

## Timing
- Reset values: state IDLE, ready=1, done=0, fault=0, loadData=0, RAMAddr=0, RAMDataOut=0, RAMWriteControl=0, internal registers 0.
- Accept at edge N. Load / SW: RAM access during cycle N+1, done high during N+2. SB/SH: read N+1, write N+2, done high during N+3. Fault: done+fault high during N+1.
- done and fault are registered, high exactly one cycle; fault=0 whenever done is from a legal access.
- ready rises in the same cycle done pulses, so back-to-back accepted requests are spaced 2 (load/SW) or 3 (SB/SH) cycles; after a fault, next request is accepted at N+1.
- req while ready=0 is ignored; core holds req and operands until it observes ready.
- Async reset mid-ACCESS or mid-WRITE: returns to IDLE immediately, RAMWriteControl drops immediately, no write committed, no done pulse for the aborted request.

## Test plan
- Preload word 0x40 = 0x8899AABB; LB addr 0x41 -> done at N+2, loadData=0xFFFFFFAA, fault=0; LBU 0x43 -> 0x00000088; LH 0x42 -> 0xFFFF8899; LHU 0x40 -> 0x0000AABB.
- SW 0x50 data 0x12345678 -> one RAMWriteControl cycle at N+1, done at N+2; LW 0x50 -> 0x12345678.
- Word 0x60 = 0xFFFFFFFF; SB 0x62 data 0xA5 -> write at N+2 of 0xFFA5FFFF, done at N+3; SH 0x60 data 0x1234 -> 0xFFA51234.
- LW 0x42, SH 0x43, funct3=011 load -> done+fault at N+1, no write, loadData unchanged, ready stays 1.
- SW 0x08 data 7 -> OutWord1=7; SW 0x00 -> done, fault=0, InpWord1 unaffected.
- Assert reset during WRITE of an SB to 0x70 -> no write to 0x70, all outputs at reset values, no done; next LW 0x44 completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle between the RV32I memory stage and the LSU.
//   req/isStore/funct3/addr/storeData : request from the core (master)
//   ready/done/fault/loadData         : handshake and result back to the core (slave)
interface load_store_unit_if #(
    parameter int unsigned dataW       = 32,
    parameter int unsigned RAMAddrSize = 32
);
    logic                   req;
    logic                   isStore;
    logic [2:0]             funct3;
    logic [RAMAddrSize-1:0] addr;
    logic [dataW-1:0]       storeData;
    logic                   ready;
    logic                   done;
    logic                   fault;
    logic [dataW-1:0]       loadData;

    modport master (
        output req, isStore, funct3, addr, storeData,
        input  ready, done, fault, loadData
    );

    modport slave (
        input  req, isStore, funct3, addr, storeData,
        output ready, done, fault, loadData
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit between the core memory stage and a word-organised, zero-delay RAM.
// Word-aligned RAM accesses, sign/zero extension of sub-word loads, and
// read-modify-write for SB/SH since the RAM only writes whole words.
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   core (slave)      : request/response bundle (ready, done, fault, loadData out)
//   RAMAddr           : word-aligned address to the RAM
//   RAMDataOut        : write data to the RAM
//   RAMWriteControl   : RAM write enable, decoded from state only
//   RAMOut            : combinational RAM read data
module load_store_unit #(
    parameter int unsigned dataW       = 32,
    parameter int unsigned RAMAddrSize = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    load_store_unit_if.slave       core,
    output logic [RAMAddrSize-1:0] RAMAddr,
    output logic [dataW-1:0]       RAMDataOut,
    output logic                   RAMWriteControl,
    input  logic [dataW-1:0]       RAMOut
);
    localparam int unsigned ByteW = 8;
    localparam int unsigned HalfW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2
    } state_t;

    state_t state, next_state;

    logic                   is_store_q;
    logic [2:0]             funct3_q;
    logic [RAMAddrSize-1:0] addr_q;
    logic [dataW-1:0]       store_data_q;
    logic [dataW-1:0]       merged_q;
    logic [dataW-1:0]       load_data_q;
    logic                   done_q;
    logic                   fault_q;

    logic                   accept;
    logic                   legal;
    logic                   is_sub_word;
    logic                   done_d;
    logic                   fault_d;
    logic [RAMAddrSize-1:0] word_addr;
    logic [4:0]             byte_shift;
    logic [4:0]             half_shift;
    logic [ByteW-1:0]       lane_b;
    logic [HalfW-1:0]       lane_h;
    logic [dataW-1:0]       load_ext;
    logic [dataW-1:0]       merged;

    assign accept      = (state == IDLE) && core.req;
    assign is_sub_word = (funct3_q[1:0] != 2'b10);
    assign word_addr   = {addr_q[RAMAddrSize-1:2], 2'b00};

    // Width code / alignment legality of the incoming request.
    always_comb begin
        legal = 1'b0;
        case (core.funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~core.addr[0];
            3'b010:  legal = (core.addr[1:0] == 2'b00);
            3'b100:  legal = ~core.isStore;
            3'b101:  legal = ~core.isStore & ~core.addr[0];
            default: legal = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; only SB/SH need the extra WRITE cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && legal) next_state = ACCESS;
            ACCESS:  next_state = (is_store_q && is_sub_word) ? WRITE : IDLE;
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: RAM controls, lane extraction/merge, next done/fault.
    always_comb begin
        RAMAddr         = '0;
        RAMDataOut      = '0;
        RAMWriteControl = 1'b0;
        done_d          = 1'b0;
        fault_d         = 1'b0;

        byte_shift = {addr_q[1:0], 3'b000};
        half_shift = {addr_q[1], 4'b0000};
        lane_b     = RAMOut[byte_shift +: ByteW];
        lane_h     = RAMOut[half_shift +: HalfW];

        case (funct3_q)
            3'b000:  load_ext = {{(dataW-ByteW){lane_b[ByteW-1]}}, lane_b};
            3'b001:  load_ext = {{(dataW-HalfW){lane_h[HalfW-1]}}, lane_h};
            3'b100:  load_ext = {{(dataW-ByteW){1'b0}}, lane_b};
            3'b101:  load_ext = {{(dataW-HalfW){1'b0}}, lane_h};
            default: load_ext = RAMOut;
        endcase

        // funct3[0] distinguishes SH (halfword lane) from SB (byte lane).
        merged = RAMOut;
        if (funct3_q[0]) begin
            merged[half_shift +: HalfW] = store_data_q[HalfW-1:0];
        end else begin
            merged[byte_shift +: ByteW] = store_data_q[ByteW-1:0];
        end

        case (state)
            IDLE: begin
                done_d  = accept && !legal;
                fault_d = accept && !legal;
            end
            ACCESS: begin
                RAMAddr = word_addr;
                if (is_store_q && !is_sub_word) begin
                    RAMWriteControl = 1'b1;
                    RAMDataOut      = store_data_q;
                end
                done_d = !(is_store_q && is_sub_word);
            end
            WRITE: begin
                RAMAddr         = word_addr;
                RAMWriteControl = 1'b1;
                RAMDataOut      = merged_q;
                done_d          = 1'b1;
            end
            default: ;
        endcase
    end

    // Request capture, load result, RMW merge word and completion flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            store_data_q <= '0;
            merged_q     <= '0;
            load_data_q  <= '0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            done_q  <= done_d;
            fault_q <= fault_d;
            if (accept) begin
                is_store_q   <= core.isStore;
                funct3_q     <= core.funct3;
                addr_q       <= core.addr;
                store_data_q <= core.storeData;
            end
            if (state == ACCESS) begin
                if (!is_store_q) begin
                    load_data_q <= load_ext;
                end
                merged_q <= merged;
            end
        end
    end

    assign core.ready    = (state == IDLE);
    assign core.done     = done_q;
    assign core.fault    = fault_q;
    assign core.loadData = load_data_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word RAM model and a completion scoreboard.
module tb_load_store_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] RAMAddr;
    logic [31:0] RAMDataOut;
    logic        RAMWriteControl;
    logic [31:0] RAMOut;
    logic [31:0] mem [0:63];

    int unsigned cyc         = 0;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned done_cnt    = 0;
    int unsigned wr_cnt      = 0;
    int unsigned wr_cyc      = 0;
    logic [31:0] wr_addr     = '0;
    logic [31:0] wr_data     = '0;
    logic [31:0] model_load  = '0;

    typedef struct {
        logic        fault;
        logic [31:0] load;
        int unsigned lat;
        int unsigned acc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    load_store_unit_if #(.dataW(32), .RAMAddrSize(32)) bus ();

    load_store_unit #(.dataW(32), .RAMAddrSize(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .core            (bus),
        .RAMAddr         (RAMAddr),
        .RAMDataOut      (RAMDataOut),
        .RAMWriteControl (RAMWriteControl),
        .RAMOut          (RAMOut)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Zero-delay word RAM; words 0 and 1 are input ports and ignore writes.
    assign RAMOut = mem[RAMAddr[7:2]];
    always @(posedge clock) begin
        if (RAMWriteControl && (RAMAddr[7:2] > 6'd1)) mem[RAMAddr[7:2]] <= RAMDataOut;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Write-enable observer: cycle number k is the period that ends at edge k.
    always @(negedge clock) begin
        if (RAMWriteControl) begin
            wr_cnt  <= wr_cnt + 1;
            wr_cyc  <= cyc + 1;
            wr_addr <= RAMAddr;
            wr_data <= RAMDataOut;
        end
    end

    // Completion monitor: pops the scoreboard on every done pulse.
    always @(negedge clock) begin
        if (!reset && bus.done) begin
            done_cnt++;
            check("done_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("done_latency", 32'(cyc + 1 - mon_e.acc), 32'(mon_e.lat));
                check("fault", 32'(bus.fault), 32'(mon_e.fault));
                check("loadData", bus.loadData, mon_e.load);
                check("ready_with_done", 32'(bus.ready), 32'd1);
            end
        end
    end

    // Issue one request, push its expectation, wait (bounded) for its done.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic exp_fault,
                         input logic [31:0] exp_load, output int unsigned n);
        exp_t        e;
        int unsigned budget;
        int unsigned start_done;
        budget = 0;
        @(negedge clock);
        while (!bus.ready && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        check("ready_before_req", 32'(bus.ready), 32'd1);
        bus.req       = 1'b1;
        bus.isStore   = st;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.storeData = d;
        start_done    = done_cnt;
        @(posedge clock);
        #1;
        n = cyc;
        if (!st && !exp_fault) model_load = exp_load;
        e.fault = exp_fault;
        e.load  = model_load;
        e.lat   = exp_fault ? 1 : ((st && f3 != 3'b010) ? 3 : 2);
        e.acc   = n;
        sb_q.push_back(e);
        // Scramble operands so the DUT must use its registered copy.
        bus.req       = 1'b0;
        bus.isStore   = ~st;
        bus.funct3    = 3'b111;
        bus.addr      = ~a;
        bus.storeData = ~d;
        budget = 0;
        while (done_cnt == start_done && budget < 10) begin
            @(posedge clock);
            #2;
            budget++;
        end
        check("done_timeout", 32'(done_cnt != start_done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        int unsigned w0;
        bus.req       = 1'b0;
        bus.isStore   = 1'b0;
        bus.funct3    = 3'b000;
        bus.addr      = '0;
        bus.storeData = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i) * 32'h0101_0101;
        mem[0]         = 32'h1111_1111;
        mem[1]         = 32'h2222_2222;
        mem[32'h40>>2] = 32'h8899_AABB;
        mem[32'h44>>2] = 32'h0BAD_BEEF;
        mem[32'h60>>2] = 32'hFFFF_FFFF;
        mem[32'h70>>2] = 32'hCAFE_F00D;

        #1;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        check("rst_loadData", bus.loadData, 32'h0);
        check("rst_RAMAddr", RAMAddr, 32'h0);
        check("rst_RAMDataOut", RAMDataOut, 32'h0);
        check("rst_RAMWriteControl", 32'(RAMWriteControl), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Sub-word loads with sign/zero extension.
        issue(1'b0, 3'b000, 32'h41, 32'h0, 1'b0, 32'hFFFF_FFAA, n);
        issue(1'b0, 3'b100, 32'h43, 32'h0, 1'b0, 32'h0000_0088, n);
        issue(1'b0, 3'b001, 32'h42, 32'h0, 1'b0, 32'hFFFF_8899, n);
        issue(1'b0, 3'b101, 32'h40, 32'h0, 1'b0, 32'h0000_AABB, n);
        issue(1'b0, 3'b000, 32'h40, 32'h0, 1'b0, 32'hFFFF_FFBB, n);

        // Word store then load back.
        w0 = wr_cnt;
        issue(1'b1, 3'b010, 32'h50, 32'h1234_5678, 1'b0, 32'h0, n);
        check("sw_wr_count", 32'(wr_cnt), 32'(w0 + 1));
        check("sw_wr_cycle", 32'(wr_cyc), 32'(n + 1));
        check("sw_wr_addr", wr_addr, 32'h50);
        check("sw_wr_data", wr_data, 32'h1234_5678);
        issue(1'b0, 3'b010, 32'h50, 32'h0, 1'b0, 32'h1234_5678, n);

        // Read-modify-write stores.
        w0 = wr_cnt;
        issue(1'b1, 3'b000, 32'h62, 32'hDEAD_BEA5, 1'b0, 32'h0, n);
        check("sb_wr_count", 32'(wr_cnt), 32'(w0 + 1));
        check("sb_wr_cycle", 32'(wr_cyc), 32'(n + 2));
        check("sb_wr_addr", wr_addr, 32'h60);
        check("sb_wr_data", wr_data, 32'hFFA5_FFFF);
        check("sb_mem", mem[32'h60>>2], 32'hFFA5_FFFF);
        issue(1'b1, 3'b001, 32'h60, 32'hCAFE_1234, 1'b0, 32'h0, n);
        check("sh_mem", mem[32'h60>>2], 32'hFFA5_1234);

        // Illegal / misaligned requests: fault, no write, loadData held.
        w0 = wr_cnt;
        issue(1'b0, 3'b010, 32'h42, 32'h0, 1'b1, 32'h0, n);
        issue(1'b1, 3'b001, 32'h43, 32'h0000_BEEF, 1'b1, 32'h0, n);
        issue(1'b0, 3'b011, 32'h40, 32'h0, 1'b1, 32'h0, n);
        issue(1'b1, 3'b100, 32'h44, 32'h0000_0077, 1'b1, 32'h0, n);
        check("fault_no_write", 32'(wr_cnt), 32'(w0));
        check("fault_mem_44", mem[32'h44>>2], 32'h0BAD_BEEF);

        // Port words: word 2 writable, words 0/1 blocked by the RAM.
        issue(1'b1, 3'b010, 32'h08, 32'h0000_0007, 1'b0, 32'h0, n);
        check("outword1", mem[2], 32'h0000_0007);
        issue(1'b1, 3'b010, 32'h00, 32'hDEAD_BEEF, 1'b0, 32'h0, n);
        check("inpword0", mem[0], 32'h1111_1111);
        check("inpword1", mem[1], 32'h2222_2222);

        // Reset asserted in the WRITE cycle of an SB to 0x70.
        @(negedge clock);
        bus.req       = 1'b1;
        bus.isStore   = 1'b1;
        bus.funct3    = 3'b000;
        bus.addr      = 32'h70;
        bus.storeData = 32'h0000_005A;
        @(posedge clock);
        #1;
        bus.req = 1'b0;
        @(posedge clock);
        #1;
        check("pre_rst_write_en", 32'(RAMWriteControl), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_write_en", 32'(RAMWriteControl), 32'd0);
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_fault", 32'(bus.fault), 32'd0);
        check("abort_loadData", bus.loadData, 32'h0);
        check("abort_RAMAddr", RAMAddr, 32'h0);
        check("abort_RAMDataOut", RAMDataOut, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_load = 32'h0;
        check("abort_mem_70", mem[32'h70>>2], 32'hCAFE_F00D);
        issue(1'b0, 3'b010, 32'h44, 32'h0, 1'b0, 32'h0BAD_BEEF, n);

        repeat (3) @(negedge clock);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
